// File: rtl/ps2_key_pkg.sv
// Shared definitions for the hps_io key event to PS/2 device-side serializer.
package ps2_key_pkg;

  localparam int unsigned TOGGLE     = 10;
  localparam int unsigned PRESSED    = 9;
  localparam int unsigned EXT        = 8;
  localparam int unsigned FRAME_BITS = 11;

  localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;

  typedef enum logic [1:0] {
    IDLE,
    BIT_HI,
    BIT_LO,
    GAP
  } tx_state_t;

  // Start bit, data LSB first, odd parity, stop bit.
  function automatic logic [FRAME_BITS-1:0] ps2_frame(input logic [7:0] b);
    return {1'b1, ~^b, b, 1'b0};
  endfunction

endpackage

// File: rtl/ps2_byte_fifo.sv
// Byte FIFO between the scancode sequencer and the PS/2 transmitter; show-ahead read.
module ps2_byte_fifo #(
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk_sys,
  input  logic                       reset,
  input  logic                       wr,
  input  logic [7:0]                 din,
  input  logic                       rd,
  output logic [7:0]                 dout,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     free_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned FW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [FW-1:0] count;
  logic          do_wr;
  logic          do_rd;

  assign do_wr = wr && (count != FW'(DEPTH));
  assign do_rd = rd && (count != '0);

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      count <= count + FW'(do_wr) - FW'(do_rd);
    end
  end

  always_ff @(posedge clk_sys) begin
    if (do_wr) mem[wr_ptr] <= din;
  end

  assign dout       = mem[rd_ptr];
  assign empty      = (count == '0);
  assign free_count = FW'(DEPTH) - count;

endmodule

// File: rtl/ps2_key_serializer.sv
// Turns hps_io ps2_key toggle events into Set-2 byte sequences and shifts them
// out as a PS/2 keyboard-side clock/data stream.
module ps2_key_serializer
  import ps2_key_pkg::*;
#(
  parameter int unsigned HALF_PERIOD = 1145,
  parameter int unsigned GAP_CYCLES  = 2290,
  parameter int unsigned FIFO_DEPTH  = 8
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [10:0] ps2_key,
  output logic        ps2_clk,
  output logic        ps2_data,
  output logic        busy,
  output logic        overflow
);

  localparam int unsigned MAX_CNT = (HALF_PERIOD > GAP_CYCLES) ? HALF_PERIOD : GAP_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_CNT + 1);
  localparam int unsigned FW      = $clog2(FIFO_DEPTH) + 1;

  logic                  prev_toggle;
  logic [1:0]            seq_left;
  logic [2:0][7:0]       seq_q;
  logic                  event_c;
  logic [1:0]            need_c;
  logic [2:0][7:0]       load_c;

  logic                  fifo_wr;
  logic                  fifo_rd;
  logic                  fifo_empty;
  logic [7:0]            fifo_dout;
  logic [FW-1:0]         free_count;

  tx_state_t             tx_state;
  logic [CNT_W-1:0]      cnt;
  logic [3:0]            idx;
  logic [FRAME_BITS-1:0] frame;

  assign event_c = (seq_left == 2'd0) && (ps2_key[TOGGLE] != prev_toggle);
  assign fifo_wr = (seq_left != 2'd0);
  assign fifo_rd = (tx_state == IDLE) && !fifo_empty;

  // Byte list for the pending event; entry 0 goes out first.
  always_comb begin
    need_c = 2'd1;
    load_c = {8'h00, 8'h00, ps2_key[7:0]};
    case ({ps2_key[EXT], ~ps2_key[PRESSED]})
      2'b11: begin
        need_c = 2'd3;
        load_c = {ps2_key[7:0], PS2_PREFIX_BRK, PS2_PREFIX_EXT};
      end
      2'b10: begin
        need_c = 2'd2;
        load_c = {8'h00, ps2_key[7:0], PS2_PREFIX_EXT};
      end
      2'b01: begin
        need_c = 2'd2;
        load_c = {8'h00, ps2_key[7:0], PS2_PREFIX_BRK};
      end
      default: ;
    endcase
  end

  // Enqueue sequencer: an event is accepted whole or dropped whole.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      prev_toggle <= ps2_key[TOGGLE];
      seq_left    <= 2'd0;
      seq_q       <= '0;
      overflow    <= 1'b0;
    end else if (seq_left != 2'd0) begin
      seq_q    <= {8'h00, seq_q[2], seq_q[1]};
      seq_left <= seq_left - 2'd1;
    end else if (event_c) begin
      prev_toggle <= ps2_key[TOGGLE];
      if (free_count < FW'(need_c)) begin
        overflow <= 1'b1;
      end else begin
        seq_left <= need_c;
        seq_q    <= load_c;
      end
    end
  end

  ps2_byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .wr         (fifo_wr),
    .din        (seq_q[0]),
    .rd         (fifo_rd),
    .dout       (fifo_dout),
    .empty      (fifo_empty),
    .free_count (free_count)
  );

  // TX FSM. GAP lasts GAP_CYCLES-1 so that, with the IDLE pop cycle, the
  // line idles exactly GAP_CYCLES between bytes.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      tx_state <= IDLE;
      ps2_clk  <= 1'b1;
      ps2_data <= 1'b1;
      cnt      <= '0;
      idx      <= '0;
      frame    <= '0;
      busy     <= 1'b0;
    end else begin
      busy <= (tx_state != IDLE) || !fifo_empty || (seq_left != 2'd0) || event_c;
      case (tx_state)
        IDLE: begin
          ps2_clk  <= 1'b1;
          ps2_data <= 1'b1;
          if (!fifo_empty) begin
            frame    <= ps2_frame(fifo_dout);
            idx      <= 4'd0;
            ps2_data <= 1'b0;
            cnt      <= CNT_W'(HALF_PERIOD - 1);
            tx_state <= BIT_HI;
          end
        end
        BIT_HI: begin
          if (cnt == '0) begin
            ps2_clk  <= 1'b0;
            cnt      <= CNT_W'(HALF_PERIOD - 1);
            tx_state <= BIT_LO;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        BIT_LO: begin
          if (cnt == '0) begin
            ps2_clk <= 1'b1;
            if (idx == 4'(FRAME_BITS - 1)) begin
              ps2_data <= 1'b1;
              cnt      <= CNT_W'(GAP_CYCLES - 2);
              tx_state <= GAP;
            end else begin
              ps2_data <= frame[idx + 4'd1];
              idx      <= idx + 4'd1;
              cnt      <= CNT_W'(HALF_PERIOD - 1);
              tx_state <= BIT_HI;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        GAP: begin
          if (cnt == '0) tx_state <= IDLE;
          else           cnt      <= cnt - CNT_W'(1);
        end
        default: tx_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_key_serializer.sv
// Directed bench: decodes frames on ps2_clk falling edges and checks them per scenario.
module tb_ps2_key_serializer;

  logic        clk_sys = 1'b0;
  logic        reset   = 1'b1;
  logic [10:0] ps2_key = 11'h400;
  logic        ps2_clk;
  logic        ps2_data;
  logic        busy;
  logic        overflow;

  int total = 0;
  int bad   = 0;

  ps2_key_serializer #(
    .HALF_PERIOD (4),
    .GAP_CYCLES  (8),
    .FIFO_DEPTH  (8)
  ) dut (
    .clk_sys  (clk_sys),
    .reset    (reset),
    .ps2_key  (ps2_key),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .busy     (busy),
    .overflow (overflow)
  );

  always #5 clk_sys = ~clk_sys;

  // Frame monitor: sample data on each falling ps2_clk, as the core's receiver does.
  int          cyc      = 0;
  int          mon_bits = 0;
  int          start_t  = 0;
  logic        prev_clk = 1'b1;
  logic [10:0] mon_word = '0;
  logic [10:0] frames[$];
  int          starts[$];

  always @(negedge clk_sys) begin
    cyc = cyc + 1;
    if (reset) begin
      mon_bits = 0;
    end else if (prev_clk && !ps2_clk) begin
      if (mon_bits == 0) start_t = cyc;
      mon_word[mon_bits] = ps2_data;
      mon_bits = mon_bits + 1;
      if (mon_bits == 11) begin
        frames.push_back(mon_word);
        starts.push_back(start_t);
        mon_bits = 0;
      end
    end
    prev_clk = ps2_clk;
  end

  task automatic send_event(input logic pressed, input logic ext, input logic [7:0] code);
    @(negedge clk_sys);
    ps2_key = {~ps2_key[10], pressed, ext, code};
  endtask

  task automatic wait_idle(input int budget, output bit timed_out);
    int n;
    repeat (4) @(negedge clk_sys);
    n = 0;
    while (busy && n < budget) begin
      @(negedge clk_sys);
      n++;
    end
    timed_out = busy;
  endtask

  task automatic test_reset();
    int hi_bad;
    reset   = 1'b1;
    ps2_key = 11'h400;
    repeat (3) @(negedge clk_sys);
    total++;
    if ({ps2_clk, ps2_data, busy, overflow} !== 4'b1100) begin
      bad++;
      $display("FAIL reset_values: clk/data/busy/ovf=%b want 1100", {ps2_clk, ps2_data, busy, overflow});
    end
    reset = 1'b0;
    frames.delete();
    starts.delete();
    hi_bad = 0;
    repeat (200) begin
      @(negedge clk_sys);
      if (ps2_clk !== 1'b1 || ps2_data !== 1'b1 || busy !== 1'b0) hi_bad++;
    end
    total++;
    if (hi_bad != 0) begin
      bad++;
      $display("FAIL reset_idle: %0d non-idle cycles want 0", hi_bad);
    end
    total++;
    if (frames.size() != 0) begin
      bad++;
      $display("FAIL reset_noframe: frames=%0d want 0", frames.size());
    end
  endtask

  task automatic test_make_code();
    bit to;
    frames.delete();
    starts.delete();
    send_event(1'b1, 1'b0, 8'h1C);
    wait_idle(400, to);
    total++;
    if (to) begin
      bad++;
      $display("FAIL make_timeout: busy=%b want 0", busy);
    end
    total++;
    if (frames.size() != 1) begin
      bad++;
      $display("FAIL make_count: frames=%0d want 1", frames.size());
    end else begin
      total++;
      if (frames[0] !== 11'h438) begin
        bad++;
        $display("FAIL make_1C: got %h want 438", frames[0]);
      end
    end
  endtask

  task automatic test_ext_release();
    bit          to;
    logic [10:0] exp[3];
    exp[0] = 11'h5C0;
    exp[1] = 11'h7E0;
    exp[2] = 11'h4EA;
    frames.delete();
    starts.delete();
    send_event(1'b0, 1'b1, 8'h75);
    wait_idle(600, to);
    total++;
    if (to || frames.size() != 3) begin
      bad++;
      $display("FAIL ext_count: frames=%0d timeout=%0b want 3/0", frames.size(), to);
    end else begin
      for (int i = 0; i < 3; i++) begin
        total++;
        if (frames[i] !== exp[i]) begin
          bad++;
          $display("FAIL ext_byte%0d: got %h want %h", i, frames[i], exp[i]);
        end
      end
      for (int i = 1; i < 3; i++) begin
        total++;
        if (starts[i] - starts[i-1] != 96) begin
          bad++;
          $display("FAIL ext_spacing%0d: got %0d want 96", i, starts[i] - starts[i-1]);
        end
      end
    end
    total++;
    if (overflow !== 1'b0) begin
      bad++;
      $display("FAIL ext_overflow: got %b want 0", overflow);
    end
  endtask

  // A second toggle pair lands while the first event is still being enqueued.
  task automatic test_double_toggle();
    bit          to;
    logic [10:0] exp[3];
    exp[0] = 11'h5C0;
    exp[1] = 11'h7E0;
    exp[2] = 11'h4E0;
    frames.delete();
    starts.delete();
    send_event(1'b0, 1'b1, 8'h70);
    send_event(1'b1, 1'b0, 8'h29);
    send_event(1'b1, 1'b0, 8'h29);
    wait_idle(600, to);
    total++;
    if (to || frames.size() != 3) begin
      bad++;
      $display("FAIL dbl_count: frames=%0d timeout=%0b want 3/0", frames.size(), to);
    end else begin
      for (int i = 0; i < 3; i++) begin
        total++;
        if (frames[i] !== exp[i]) begin
          bad++;
          $display("FAIL dbl_byte%0d: got %h want %h", i, frames[i], exp[i]);
        end
      end
    end
    total++;
    if (overflow !== 1'b0) begin
      bad++;
      $display("FAIL dbl_overflow: got %b want 0", overflow);
    end
  endtask

  // A 1-byte frame holds the transmitter while three 3-byte events arrive.
  task automatic test_overflow();
    bit          to;
    logic [10:0] exp[7];
    exp[0] = 11'h42C;
    exp[1] = 11'h5C0;
    exp[2] = 11'h7E0;
    exp[3] = 11'h4D6;
    exp[4] = 11'h5C0;
    exp[5] = 11'h7E0;
    exp[6] = 11'h6E8;
    frames.delete();
    starts.delete();
    send_event(1'b1, 1'b0, 8'h16);
    repeat (4) @(negedge clk_sys);
    send_event(1'b0, 1'b1, 8'h6B);
    repeat (4) @(negedge clk_sys);
    send_event(1'b0, 1'b1, 8'h74);
    repeat (4) @(negedge clk_sys);
    send_event(1'b0, 1'b1, 8'h72);
    wait_idle(1200, to);
    total++;
    if (overflow !== 1'b1) begin
      bad++;
      $display("FAIL ovf_flag: got %b want 1", overflow);
    end
    total++;
    if (to || frames.size() != 7) begin
      bad++;
      $display("FAIL ovf_count: frames=%0d timeout=%0b want 7/0", frames.size(), to);
    end else begin
      for (int i = 0; i < 7; i++) begin
        total++;
        if (frames[i] !== exp[i]) begin
          bad++;
          $display("FAIL ovf_byte%0d: got %h want %h", i, frames[i], exp[i]);
        end
      end
    end
  endtask

  task automatic test_reset_midframe();
    int n;
    int hi_bad;
    frames.delete();
    starts.delete();
    send_event(1'b1, 1'b0, 8'h5A);
    repeat (4) @(negedge clk_sys);
    send_event(1'b1, 1'b0, 8'h29);
    n = 0;
    while (mon_bits != 6 && n < 200) begin
      @(negedge clk_sys);
      n++;
    end
    total++;
    if (mon_bits != 6) begin
      bad++;
      $display("FAIL mid_reach_bit5: bits=%0d want 6", mon_bits);
    end
    reset = 1'b1;
    @(negedge clk_sys);
    total++;
    if ({ps2_clk, ps2_data, busy, overflow} !== 4'b1100) begin
      bad++;
      $display("FAIL mid_reset_out: clk/data/busy/ovf=%b want 1100", {ps2_clk, ps2_data, busy, overflow});
    end
    @(negedge clk_sys);
    reset = 1'b0;
    frames.delete();
    hi_bad = 0;
    repeat (300) begin
      @(negedge clk_sys);
      if (ps2_clk !== 1'b1 || ps2_data !== 1'b1 || busy !== 1'b0) hi_bad++;
    end
    total++;
    if (hi_bad != 0 || frames.size() != 0) begin
      bad++;
      $display("FAIL mid_after: non-idle=%0d frames=%0d want 0/0", hi_bad, frames.size());
    end
  endtask

  initial begin
    test_reset();
    test_make_code();
    test_ext_release();
    test_double_toggle();
    test_overflow();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
